// File: rtl/ft232h_pkg.sv
// Shared types and helpers for the FT232H synchronous-245 transmit engine.
package ft232h_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   localparam logic [3:0] HDR_MAGIC = 4'hA;

   // Bytes put on the bus per accepted word: payload bytes plus optional header.
   function automatic int unsigned nbeats(input int unsigned data_w, input int unsigned hdr_en);
      return (data_w / 32'd8) + ((hdr_en != 32'd0) ? 32'd1 : 32'd0);
   endfunction

endpackage

// File: rtl/ft232h_tx_engine_if.sv
// Word stream from the acquisition path into the FT232H transmit engine.
interface ft232h_tx_engine_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CH_W   = 2
);
   logic [DATA_W-1:0] data;
   logic [CH_W-1:0]   ch;
   logic              valid;
   logic              ready;

   modport master (output data, output ch, output valid, input ready);
   modport slave  (input data, input ch, input valid, output ready);
endinterface

// File: rtl/ft232h_flush_timer.sv
// Idle-timeout counter, latched flush request and the single-cycle SIWU# pulse.
module ft232h_flush_timer #(
   parameter int unsigned FLUSH_IDLE = 64
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic idle_i,        // engine is in IDLE this cycle
   input  logic xfer_i,        // a byte is accepted by the FT232H at this edge
   input  logic accept_i,      // a word is accepted from the stream at this edge
   input  logic flush_i,       // single-cycle explicit flush request
   output logic flush_req_c_o, // combinational: a flush is wanted now
   output logic siwu_n_o
);

   localparam int unsigned CNT_W = (FLUSH_IDLE == 32'd0) ? 1 : $clog2(FLUSH_IDLE + 32'd1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLUSH_IDLE);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic armed_q, armed_d;
   logic pend_q, pend_d;
   logic siwu_n_q, siwu_n_d;
   logic auto_c, fire_c;

   // Auto-flush only once something has been written since the last flush.
   assign auto_c        = (FLUSH_IDLE != 32'd0) && armed_q && (cnt_q == CNT_MAX);
   assign flush_req_c_o = flush_i || pend_q || auto_c;
   assign fire_c        = idle_i && flush_req_c_o;
   assign siwu_n_o      = siwu_n_q;

   // Next-state for the idle counter, arm flag and pending request.
   always_comb begin
      cnt_d    = cnt_q;
      armed_d  = armed_q;
      pend_d   = pend_q;
      siwu_n_d = !fire_c;
      if (xfer_i) armed_d = 1'b1;
      if (flush_i) pend_d = 1'b1;
      if (idle_i && armed_q && (FLUSH_IDLE != 32'd0) && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
      if (accept_i) cnt_d = '0;
      if (fire_c) begin
         cnt_d   = '0;
         armed_d = 1'b0;
         pend_d  = 1'b0;
      end
   end

   // Timer state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q    <= '0;
         armed_q  <= 1'b0;
         pend_q   <= 1'b0;
         siwu_n_q <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         armed_q  <= armed_d;
         pend_q   <= pend_d;
         siwu_n_q <= siwu_n_d;
      end
   end

endmodule

// File: rtl/ft232h_tx_engine.sv
// FT232H sync-245 transmitter: serialises tagged words onto ADBUS with TXE# back-pressure.
module ft232h_tx_engine
   import ft232h_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned HDR_EN     = 1,
   parameter int unsigned FLUSH_IDLE = 64
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   ft232h_tx_engine_if.slave   s_if,
   input  logic                flush_i,
   input  logic                ft_txe_n_i,
   output logic [7:0]          ft_data_o,
   output logic                ft_wr_n_o,
   output logic                ft_siwu_n_o,
   output logic                ft_rd_n_o,
   output logic                ft_oe_n_o,
   output logic                ft_rst_n_o,
   output logic                ft_pwrsav_n_o,
   output logic [31:0]         stat_bytes_o,
   output logic [15:0]         stat_stall_o
);

   localparam int unsigned CH_W   = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned NB     = nbeats(DATA_W, HDR_EN);
   localparam int unsigned SR_W   = NB * 32'd8;
   localparam int unsigned BEAT_W = (NB > 32'd1) ? $clog2(NB) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NB - 32'd1);

   state_e              state_q, state_d;
   logic [SR_W-1:0]     sr_q, sr_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                wr_n_q, wr_n_d;
   logic [31:0]         bytes_q;
   logic [15:0]         stall_q;

   logic [CH_W-1:0]     ch_c;
   logic [SR_W-1:0]     word_c;
   logic                last_c, xfer_c, ready_c, accept_c, flush_req_c;

   assign ch_c     = s_if.ch;
   assign last_c   = (beat_q == BEAT_LAST);
   assign xfer_c   = !wr_n_q && !ft_txe_n_i;
   assign accept_c = s_if.valid && ready_c;

   assign s_if.ready    = ready_c;
   assign ft_data_o     = sr_q[7:0];
   assign ft_wr_n_o     = wr_n_q;
   assign ft_rd_n_o     = 1'b1;
   assign ft_oe_n_o     = 1'b1;
   assign ft_rst_n_o    = 1'b1;
   assign ft_pwrsav_n_o = 1'b1;
   assign stat_bytes_o  = bytes_q;
   assign stat_stall_o  = stall_q;

   // Byte image of the incoming word, lowest byte goes out first.
   always_comb begin
      word_c = '0;
      if (HDR_EN != 32'd0) word_c = SR_W'({s_if.data, HDR_MAGIC, 4'(ch_c)});
      else                 word_c = SR_W'(s_if.data);
   end

   ft232h_flush_timer #(.FLUSH_IDLE(FLUSH_IDLE)) u_flush (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .idle_i        (state_q == ST_IDLE),
      .xfer_i        (xfer_c),
      .accept_i      (accept_c),
      .flush_i       (flush_i),
      .flush_req_c_o (flush_req_c),
      .siwu_n_o      (ft_siwu_n_o)
   );

   // Next-state, handshake and shift-register control; a pending flush blocks new words.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      beat_d  = beat_q;
      wr_n_d  = wr_n_q;
      ready_c = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ready_c = !flush_req_c;
            if (flush_req_c) begin
               state_d = ST_FLUSH;
            end else if (s_if.valid) begin
               state_d = ST_SEND;
               sr_d    = word_c;
               beat_d  = '0;
               wr_n_d  = 1'b0;
            end
         end
         ST_SEND: begin
            ready_c = last_c && !ft_txe_n_i && !flush_req_c;
            if (xfer_c) begin
               if (!last_c) begin
                  sr_d   = sr_q >> 8;
                  beat_d = beat_q + BEAT_W'(1);
               end else if (s_if.valid && ready_c) begin
                  sr_d   = word_c;
                  beat_d = '0;
               end else begin
                  state_d = ST_IDLE;
                  beat_d  = '0;
                  wr_n_d  = 1'b1;
               end
            end
         end
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Engine state registers; reset drops any partial word and releases WR#.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         beat_q  <= '0;
         wr_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         beat_q  <= beat_d;
         wr_n_q  <= wr_n_d;
      end
   end

   // Transfer count (wrapping) and stall count (saturating).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         bytes_q <= '0;
         stall_q <= '0;
      end else begin
         if (xfer_c) bytes_q <= bytes_q + 32'd1;
         if (!wr_n_q && ft_txe_n_i && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_ft232h_tx_engine.sv
// Directed and randomized checks of ft232h_tx_engine against a byte-queue reference model.
module tb_ft232h_tx_engine;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: 16-bit words with header, auto-flush after 64 idle cycles.
   logic        flush_a, txe_a, wr_a, siwu_a, rd_a, oe_a, frst_a, pws_a;
   logic [7:0]  data_a;
   logic [31:0] bytes_a;
   logic [15:0] stall_a;
   ft232h_tx_engine_if #(.DATA_W(16), .CH_W(2)) ifa ();
   ft232h_tx_engine #(.DATA_W(16), .NUM_CH(4), .HDR_EN(1), .FLUSH_IDLE(64)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .s_if(ifa), .flush_i(flush_a), .ft_txe_n_i(txe_a),
      .ft_data_o(data_a), .ft_wr_n_o(wr_a), .ft_siwu_n_o(siwu_a), .ft_rd_n_o(rd_a),
      .ft_oe_n_o(oe_a), .ft_rst_n_o(frst_a), .ft_pwrsav_n_o(pws_a),
      .stat_bytes_o(bytes_a), .stat_stall_o(stall_a));

   // Instance B: 32-bit words, no header, auto-flush disabled.
   logic        flush_b, txe_b, wr_b, siwu_b, rd_b, oe_b, frst_b, pws_b;
   logic [7:0]  data_b;
   logic [31:0] bytes_b;
   logic [15:0] stall_b;
   ft232h_tx_engine_if #(.DATA_W(32), .CH_W(2)) ifb ();
   ft232h_tx_engine #(.DATA_W(32), .NUM_CH(4), .HDR_EN(0), .FLUSH_IDLE(0)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .s_if(ifb), .flush_i(flush_b), .ft_txe_n_i(txe_b),
      .ft_data_o(data_b), .ft_wr_n_o(wr_b), .ft_siwu_n_o(siwu_b), .ft_rd_n_o(rd_b),
      .ft_oe_n_o(oe_b), .ft_rst_n_o(frst_b), .ft_pwrsav_n_o(pws_b),
      .stat_bytes_o(bytes_b), .stat_stall_o(stall_b));

   int n_chk, n_pass, cyc_n;
   logic [7:0] exp_a[$], exp_b[$], got_a[$];
   int last_xfer_a, siwu_idx_a, siwu_cnt_a, acc_cnt_a, acc_idx_a;
   int xfer_cnt_b, first_xfer_b, last_xfer_b, acc_cnt_b, siwu_cnt_b;
   bit acc_now_a, acc_now_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: inputs are already set; observe just after the negedge, then wait for the next one.
   task automatic cyc();
      logic [31:0] e;
      #1;
      cyc_n++;
      acc_now_a = 1'b0;
      acc_now_b = 1'b0;
      if (!wr_a && !txe_a) begin
         e = (exp_a.size() > 0) ? 32'(exp_a.pop_front()) : 32'h1FF;
         chk("a_byte", 32'(data_a), e);
         got_a.push_back(data_a);
         last_xfer_a = cyc_n;
      end
      if (ifa.valid && ifa.ready) begin
         exp_a.push_back({4'hA, 2'b00, ifa.ch});
         exp_a.push_back(ifa.data[7:0]);
         exp_a.push_back(ifa.data[15:8]);
         acc_now_a = 1'b1;
         acc_cnt_a++;
         acc_idx_a = cyc_n;
      end
      if (!siwu_a) begin
         siwu_cnt_a++;
         siwu_idx_a = cyc_n;
         chk("a_wr_high_in_flush", 32'(wr_a), 32'd1);
      end
      if (!wr_b && !txe_b) begin
         e = (exp_b.size() > 0) ? 32'(exp_b.pop_front()) : 32'h1FF;
         chk("b_byte", 32'(data_b), e);
         xfer_cnt_b++;
         if (first_xfer_b < 0) first_xfer_b = cyc_n;
         last_xfer_b = cyc_n;
      end
      if (ifb.valid && ifb.ready) begin
         for (int k = 0; k < 4; k++) exp_b.push_back(ifb.data[8*k +: 8]);
         acc_now_b = 1'b1;
         acc_cnt_b++;
      end
      if (!siwu_b) siwu_cnt_b++;
      @(negedge clk);
   endtask

   int t_last, t_acc, base_acc, prev_acc, gap_bad, n;

   initial begin
      n_chk = 0; n_pass = 0; cyc_n = 0;
      last_xfer_a = 0; siwu_idx_a = 0; siwu_cnt_a = 0; acc_cnt_a = 0; acc_idx_a = 0;
      xfer_cnt_b = 0; first_xfer_b = -1; last_xfer_b = 0; acc_cnt_b = 0; siwu_cnt_b = 0;
      rst_n = 1'b0;
      flush_a = 1'b0; txe_a = 1'b0; ifa.valid = 1'b0; ifa.data = '0; ifa.ch = '0;
      flush_b = 1'b0; txe_b = 1'b0; ifb.valid = 1'b0; ifb.data = '0; ifb.ch = '0;
      @(negedge clk);
      cyc(); cyc();

      // Reset state
      chk("rst_wr_n", 32'(wr_a), 32'd1);
      chk("rst_siwu_n", 32'(siwu_a), 32'd1);
      chk("rst_data", 32'(data_a), 32'd0);
      chk("rst_ready", 32'(ifa.ready), 32'd1);
      chk("rst_bytes", bytes_a, 32'd0);
      chk("rst_stall", 32'(stall_a), 32'd0);
      chk("const_pins", 32'({rd_a, oe_a, frst_a, pws_a}), 32'hF);
      chk("rst_wr_n_b", 32'(wr_b), 32'd1);
      rst_n = 1'b1;
      cyc(); cyc();

      // BEEF on channel 2, TXE# low: A2, EF, BE on consecutive edges
      got_a.delete();
      ifa.valid = 1'b1; ifa.data = 16'hBEEF; ifa.ch = 2'd2;
      cyc();
      chk("t1_accept", 32'(acc_now_a), 32'd1);
      ifa.valid = 1'b0; ifa.data = 16'($urandom());
      chk("t1_wr_low_next", 32'(wr_a), 32'd0);
      chk("t1_hdr_on_bus", 32'(data_a), 32'hA2);
      cyc(); cyc(); cyc();
      chk("t1_bytes_after_3", bytes_a, 32'd3);
      chk("t1_wr_released", 32'(wr_a), 32'd1);
      chk("t1_nbytes", 32'(got_a.size()), 32'd3);
      chk("t1_b0", 32'(got_a[0]), 32'hA2);
      chk("t1_b1", 32'(got_a[1]), 32'hEF);
      chk("t1_b2", 32'(got_a[2]), 32'hBE);

      // Idle timeout: 64 counted idle cycles, one request cycle, then the registered pulse
      t_last = last_xfer_a;
      repeat (120) cyc();
      chk("t4_one_pulse", 32'(siwu_cnt_a), 32'd1);
      chk("t4_pulse_delay", 32'(siwu_idx_a - t_last), 32'd66);

      // Same word, TXE# high for 5 cycles after the header byte
      got_a.delete();
      ifa.valid = 1'b1; ifa.data = 16'hBEEF; ifa.ch = 2'd2;
      cyc();
      ifa.valid = 1'b0;
      cyc();
      txe_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t2_held_data", 32'(data_a), 32'hEF);
         chk("t2_held_wr", 32'(wr_a), 32'd0);
         cyc();
      end
      txe_a = 1'b0;
      cyc(); cyc(); cyc();
      chk("t2_stall", 32'(stall_a), 32'd5);
      chk("t2_bytes", bytes_a, 32'd6);
      chk("t2_nbytes", 32'(got_a.size()), 32'd3);
      chk("t2_b1", 32'(got_a[1]), 32'hEF);
      chk("t2_b2", 32'(got_a[2]), 32'hBE);

      // flush_i during SEND with a second word already waiting
      ifa.valid = 1'b1; ifa.data = 16'h1234; ifa.ch = 2'd1;
      cyc();
      ifa.data = 16'h5678; ifa.ch = 2'd3;
      t_acc = acc_cnt_a;
      n = siwu_cnt_a;
      flush_a = 1'b1;
      cyc();
      flush_a = 1'b0;
      for (int i = 0; i < 20 && acc_cnt_a == t_acc; i++) cyc();
      ifa.valid = 1'b0;
      chk("t3_w2_accepted", 32'(acc_cnt_a - t_acc), 32'd1);
      chk("t3_one_pulse", 32'(siwu_cnt_a - n), 32'd1);
      chk("t3_pulse_after_last", 32'(siwu_idx_a - last_xfer_a), 32'd2);
      chk("t3_word_after_flush", 32'(acc_idx_a - siwu_idx_a), 32'd1);
      repeat (5) cyc();
      chk("t3_drained", 32'(exp_a.size()), 32'd0);

      // Reset in the middle of a word
      ifa.valid = 1'b1; ifa.data = 16'hCAFE; ifa.ch = 2'd3;
      cyc();
      ifa.valid = 1'b0;
      cyc();
      chk("t5_mid_word_wr", 32'(wr_a), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_wr_high", 32'(wr_a), 32'd1);
      exp_a.delete();
      exp_b.delete();
      cyc(); cyc();
      chk("t5_rst_bytes", bytes_a, 32'd0);
      rst_n = 1'b1;
      cyc();
      got_a.delete();
      base_acc = acc_cnt_a;
      ifa.valid = 1'b1; ifa.data = 16'($urandom()); ifa.ch = 2'd0;
      cyc();
      ifa.valid = 1'b0;
      repeat (4) cyc();
      chk("t5_nbytes", 32'(got_a.size()), 32'd3);
      chk("t5_hdr_first", 32'(got_a[0]), 32'hA0);

      // 100 back-to-back 32-bit words without header
      gap_bad = 0; prev_acc = 0; n = 0;
      ifb.valid = 1'b1; ifb.data = $urandom(); ifb.ch = 2'($urandom());
      while (acc_cnt_b < 100 && n < 1000) begin
         cyc();
         n++;
         if (acc_now_b) begin
            if (acc_cnt_b > 1 && cyc_n - prev_acc != 4) gap_bad++;
            prev_acc = cyc_n;
            ifb.data = $urandom();
            ifb.ch   = 2'($urandom());
         end
      end
      ifb.valid = 1'b0;
      repeat (80) cyc();
      chk("b_words", 32'(acc_cnt_b), 32'd100);
      chk("b_transfers", 32'(xfer_cnt_b), 32'd400);
      chk("b_contiguous", 32'(last_xfer_b - first_xfer_b), 32'd399);
      chk("b_no_bubble", 32'(gap_bad), 32'd0);
      chk("b_stat_bytes", bytes_b, 32'd400);
      chk("b_no_autoflush", 32'(siwu_cnt_b), 32'd0);

      // Randomized traffic on A with TXE# stalls and stray flush requests
      for (int i = 0; i < 400; i++) begin
         txe_a   = ($urandom_range(0, 3) == 0);
         flush_a = ($urandom_range(0, 40) == 0);
         if (!ifa.valid || acc_now_a) begin
            ifa.valid = 1'($urandom_range(0, 1));
            ifa.data  = 16'($urandom());
            ifa.ch    = 2'($urandom());
         end
         cyc();
      end
      ifa.valid = 1'b0; flush_a = 1'b0; txe_a = 1'b0;
      repeat (20) cyc();
      chk("rand_drained", 32'(exp_a.size()), 32'd0);
      chk("rand_stat_bytes", bytes_a, 32'(3 * (acc_cnt_a - base_acc)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
